// File: rtl/light_pkg.sv
// Shared colour codes and head state encoding for the light command interface.
// Latency: n/a (types, constants and a pure decode function only).
// Backpressure: n/a.
package light_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'd0;
  localparam logic [1:0] LIGHT_YELLOW  = 2'd1;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'd2;
  localparam logic [1:0] LIGHT_GREEN   = 2'd3;

  // Head states; also used by light_controller to track the responder.
  typedef enum logic [1:0] {
    ST_RED    = 2'd0,
    ST_YELLOW = 2'd1,
    ST_FAULT  = 2'd2,
    ST_GREEN  = 2'd3
  } light_state_e;

  // Colour reported to the controller; a faulted head shows red.
  function automatic logic [1:0] state_to_color(light_state_e s);
    logic [1:0] c;
    c = LIGHT_RED;
    case (s)
      ST_GREEN:  c = LIGHT_GREEN;
      ST_YELLOW: c = LIGHT_YELLOW;
      default:   c = LIGHT_RED;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Cycles-in-state counter: zero on the first cycle of a state, saturating increment.
// Latency: clear or increment takes effect on the following clock edge.
// Backpressure: none; free-running.
module dwell_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on clear, otherwise count up and hold at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/signal_head_driver.sv
// Signal head responder: takes colour commands, sequences lamps GREEN->YELLOW->RED, sticky fault.
// Latency: command accepted at edge N shows on state/lamps from cycle N+1; yellow lasts YELLOW_CYCLES.
// Backpressure: cmd_ready low during min dwell, all of yellow and in fault; command waits until ready.
module signal_head_driver
  import light_pkg::*;
#(
  parameter int YELLOW_CYCLES    = 4,
  parameter int MIN_GREEN_CYCLES = 8,
  parameter int MIN_RED_CYCLES   = 2,
  parameter int CNT_W            = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  input  logic [1:0] set_light_color,
  output logic       cmd_ready,
  output logic [1:0] current_light_state,
  output logic       lamp_red,
  output logic       lamp_yellow,
  output logic       lamp_green,
  output logic       fault
);

  light_state_e     state_q;
  light_state_e     state_d;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clear;
  logic             accept;

  // Dwell counter restarts whenever the head changes state.
  dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (cnt_clear),
    .cnt   (cnt)
  );

  // Ready depends only on registered state and dwell count, never on cmd_valid.
  always_comb begin
    cmd_ready = 1'b0;
    case (state_q)
      ST_RED:   cmd_ready = (cnt >= CNT_W'(MIN_RED_CYCLES - 1));
      ST_GREEN: cmd_ready = (cnt >= CNT_W'(MIN_GREEN_CYCLES - 1));
      default:  cmd_ready = 1'b0;
    endcase
  end

  assign accept = cmd_valid & cmd_ready;

  // Next-state: only legal transitions; same-colour or backwards requests are accepted no-ops.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RED: begin
        if (accept) begin
          if (set_light_color == LIGHT_GREEN) begin
            state_d = ST_GREEN;
          end else if (set_light_color == LIGHT_ILLEGAL) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_GREEN: begin
        if (accept) begin
          if (set_light_color == LIGHT_RED || set_light_color == LIGHT_YELLOW) begin
            state_d = ST_YELLOW;
          end else if (set_light_color == LIGHT_ILLEGAL) begin
            state_d = ST_FAULT;
          end
        end
      end
      ST_YELLOW: begin
        if (cnt == CNT_W'(YELLOW_CYCLES - 1)) begin
          state_d = ST_RED;
        end
      end
      default: state_d = ST_FAULT;
    endcase
  end

  assign cnt_clear = (state_d != state_q);

  // State register; reset always lands in red, which also clears the fault.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RED;
    end else begin
      state_q <= state_d;
    end
  end

  assign current_light_state = state_to_color(state_q);
  assign lamp_red            = (state_q == ST_RED) || (state_q == ST_FAULT);
  assign lamp_yellow         = (state_q == ST_YELLOW);
  assign lamp_green          = (state_q == ST_GREEN);
  assign fault               = (state_q == ST_FAULT);

endmodule

// File: tb/tb_signal_head_driver.sv
module tb_signal_head_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic [1:0] set_light_color;
  logic       cmd_ready;
  logic [1:0] current_light_state;
  logic       lamp_red;
  logic       lamp_yellow;
  logic       lamp_green;
  logic       fault;

  always #5 clk = ~clk;

  signal_head_driver dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .cmd_valid           (cmd_valid),
    .set_light_color     (set_light_color),
    .cmd_ready           (cmd_ready),
    .current_light_state (current_light_state),
    .lamp_red            (lamp_red),
    .lamp_yellow         (lamp_yellow),
    .lamp_green          (lamp_green),
    .fault               (fault)
  );

  typedef struct {
    logic [1:0] st;
    logic       rdy;
    logic       flt;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Queue the expected post-edge outputs for the next n cycles.
  task automatic expect_n(input int n, input logic [1:0] st, input logic rdy,
                          input logic flt, input string tag);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.st  = st;
      e.rdy = rdy;
      e.flt = flt;
      e.tag = $sformatf("%s[%0d]", tag, i);
      sb.push_back(e);
    end
  endtask

  // Advance n cycles; after each edge compare outputs against the queued expectation.
  task automatic run(input int n);
    exp_t       e;
    logic [2:0] exp_l;
    logic [2:0] obs_l;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e     = sb.pop_front();
        exp_l = {e.st == 2'd0, e.st == 2'd1, e.st == 2'd3};
        obs_l = {lamp_red, lamp_yellow, lamp_green};
        checks++;
        assert (current_light_state === e.st) else begin
          errors++;
          $error("FAIL %s state got %0d want %0d", e.tag, current_light_state, e.st);
        end
        checks++;
        assert (obs_l === exp_l) else begin
          errors++;
          $error("FAIL %s lamps(ryg) got %b want %b", e.tag, obs_l, exp_l);
        end
        checks++;
        assert (cmd_ready === e.rdy) else begin
          errors++;
          $error("FAIL %s cmd_ready got %b want %b", e.tag, cmd_ready, e.rdy);
        end
        checks++;
        assert (fault === e.flt) else begin
          errors++;
          $error("FAIL %s fault got %b want %b", e.tag, fault, e.flt);
        end
      end
    end
  endtask

  initial begin
    rst_n           = 1'b0;
    cmd_valid       = 1'b0;
    set_light_color = 2'd0;

    // Reset: red, counter 0 so not yet ready.
    expect_n(2, 2'd0, 1'b0, 1'b0, "reset");
    run(2);
    rst_n = 1'b1;
    // Ready rises on the second cycle after reset.
    expect_n(1, 2'd0, 1'b1, 1'b0, "ready_rise");
    run(1);

    // Red and yellow requests while red are accepted no-ops.
    cmd_valid = 1'b1; set_light_color = 2'd0;
    expect_n(1, 2'd0, 1'b1, 1'b0, "red_noop");
    run(1);
    set_light_color = 2'd1;
    expect_n(1, 2'd0, 1'b1, 1'b0, "red_yel_noop");
    run(1);

    // Green held from entry: 7 cycles not ready, no-op acceptance from the 8th.
    set_light_color = 2'd3;
    expect_n(7, 2'd3, 1'b0, 1'b0, "green_dwell");
    expect_n(2, 2'd3, 1'b1, 1'b0, "green_noop");
    run(9);

    // Red from ready green: exactly 4 yellow cycles, red held through yellow stalls.
    set_light_color = 2'd0;
    expect_n(4, 2'd1, 1'b0, 1'b0, "yellow");
    expect_n(1, 2'd0, 1'b0, 1'b0, "red_after_y");
    expect_n(1, 2'd0, 1'b1, 1'b0, "red_ready");
    run(6);

    // Red held from green entry: yellow starts on the 9th cycle.
    set_light_color = 2'd3;
    expect_n(1, 2'd3, 1'b0, 1'b0, "green2_entry");
    run(1);
    set_light_color = 2'd0;
    expect_n(6, 2'd3, 1'b0, 1'b0, "green2_dwell");
    expect_n(1, 2'd3, 1'b1, 1'b0, "green2_ready");
    expect_n(2, 2'd1, 1'b0, 1'b0, "yellow2");
    run(9);

    // Reset during the 2nd yellow cycle: red next cycle, yellow not resumed.
    rst_n = 1'b0;
    expect_n(1, 2'd0, 1'b0, 1'b0, "rst_in_yellow");
    run(1);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    expect_n(5, 2'd0, 1'b1, 1'b0, "post_rst_red");
    run(5);

    // Illegal code while ready: sticky fault, green ignored.
    cmd_valid = 1'b1; set_light_color = 2'd2;
    expect_n(1, 2'd0, 1'b0, 1'b1, "fault_entry");
    run(1);
    set_light_color = 2'd3;
    expect_n(5, 2'd0, 1'b0, 1'b1, "fault_sticky");
    run(5);
    rst_n = 1'b0;
    expect_n(1, 2'd0, 1'b0, 1'b0, "fault_clear");
    run(1);
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    expect_n(1, 2'd0, 1'b1, 1'b0, "fault_rec");
    run(1);

    // Long red dwell: counter saturates and ready never drops.
    expect_n(300, 2'd0, 1'b1, 1'b0, "sat");
    run(300);

    // Illegal code while green not ready stalls; taken once ready.
    cmd_valid = 1'b1; set_light_color = 2'd3;
    expect_n(1, 2'd3, 1'b0, 1'b0, "g3_entry");
    run(1);
    set_light_color = 2'd2;
    expect_n(6, 2'd3, 1'b0, 1'b0, "g3_stall");
    expect_n(1, 2'd3, 1'b1, 1'b0, "g3_ready");
    expect_n(1, 2'd0, 1'b0, 1'b1, "g3_fault");
    run(8);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain left %0d want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
